// File: rtl/frame_pkg.sv
// Shared frame geometry and FSM encoding for the SRAM frame reader.
// An 80x60 pixel frame is held in SRAM and read back SRAM_PARALLEL pixels
// per beat, so a frame is BEATS beats long.
package frame_pkg;

  localparam int PIXEL_COLUMN  = 80;
  localparam int PIXEL_ROW     = 60;
  localparam int NUM_DATA      = PIXEL_COLUMN * PIXEL_ROW;
  localparam int SRAM_PARALLEL = 6;
  localparam int ADDR_W        = 13;
  localparam int DATA_W        = 16;
  localparam int BEATS         = NUM_DATA / SRAM_PARALLEL;
  localparam int BEAT_W        = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sram_frame_reader_if.sv
// Bus bundle between the frame reader, its SRAM read lanes and the
// downstream pixel consumer.
//   o_read_address : per-lane SRAM read address (reader -> SRAM)
//   i_read_data    : per-lane SRAM read data, same-cycle response (SRAM -> reader)
//   o_data         : registered pixel beat, one pixel per lane
//   o_valid        : o_data/o_beat/o_last valid
//   i_ready        : consumer accepts the beat when o_valid & i_ready
//   o_beat         : beat index of o_data
//   o_last         : o_data is the final beat of the frame
// master = reader side, slave = SRAM/consumer side.
interface sram_frame_reader_if
  import frame_pkg::*;
#(
  parameter int NUM_READ = SRAM_PARALLEL
);

  logic [NUM_READ-1:0][ADDR_W-1:0] o_read_address;
  logic [NUM_READ-1:0][DATA_W-1:0] i_read_data;
  logic [NUM_READ-1:0][DATA_W-1:0] o_data;
  logic                            o_valid;
  logic                            i_ready;
  logic [BEAT_W-1:0]               o_beat;
  logic                            o_last;

  modport master (
    output o_read_address,
    input  i_read_data,
    output o_data,
    output o_valid,
    input  i_ready,
    output o_beat,
    output o_last
  );

  modport slave (
    input  o_read_address,
    output i_read_data,
    input  o_data,
    input  o_valid,
    output i_ready,
    input  o_beat,
    input  o_last
  );

endinterface

// File: rtl/sram_frame_reader.sv
// Scans one frame out of a NUM_READ-lane SRAM on request and streams it as
// NUM_DATA/NUM_READ beats over a valid/ready handshake.
// Ports:
//   i_clk   : rising-edge clock
//   i_rst   : asynchronous active-high reset, aborts any frame in flight
//   i_start : single-cycle frame request, ignored while o_busy
//   o_busy  : high while scanning or draining the final beat
//   o_done  : one-cycle pulse after the final beat is accepted
//   bus     : SRAM lanes + pixel stream (see sram_frame_reader_if)
module sram_frame_reader
  import frame_pkg::*;
#(
  parameter int NUM_READ = SRAM_PARALLEL,
  parameter int NUM_DATA = frame_pkg::NUM_DATA
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  sram_frame_reader_if.master bus
);

  localparam int LAST_BEAT = NUM_DATA / NUM_READ - 1;

  if ((NUM_DATA % NUM_READ) != 0) begin : g_geometry_check
    $error("NUM_DATA must be a multiple of NUM_READ");
  end

  state_t                          state;
  logic [ADDR_W-1:0]               base;
  logic [BEAT_W-1:0]               cnt;
  logic [NUM_READ-1:0][DATA_W-1:0] data_p0;
  logic                            vld_p0;
  logic [BEAT_W-1:0]               beat_p0;
  logic                            last_p0;
  logic                            done_r;
  logic                            load;
  logic                            at_last;

  // The output register refills whenever it is empty or being drained this
  // cycle, so a handshake and the next load always coincide in SCAN.
  assign load    = (state == S_SCAN) && (!vld_p0 || bus.i_ready);
  assign at_last = (cnt == BEAT_W'(LAST_BEAT));

  // Outside SCAN the lanes park on 0..NUM_READ-1 so no stray high address
  // is ever presented to the SRAM.
  always_comb begin
    for (int k = 0; k < NUM_READ; k++) begin
      if (state == S_SCAN) begin
        bus.o_read_address[k] = base + ADDR_W'(k);
      end else begin
        bus.o_read_address[k] = ADDR_W'(k);
      end
    end
  end

  // ---- stage p0: SRAM read data captured into the output beat register ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= S_IDLE;
      base    <= '0;
      cnt     <= '0;
      data_p0 <= '0;
      vld_p0  <= 1'b0;
      beat_p0 <= '0;
      last_p0 <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state <= S_SCAN;
            base  <= '0;
            cnt   <= '0;
          end
        end
        S_SCAN: begin
          if (load) begin
            data_p0 <= bus.i_read_data;
            vld_p0  <= 1'b1;
            beat_p0 <= cnt;
            last_p0 <= at_last;
            // The final beat leaves base/cnt untouched; DRAIN only waits
            // for that beat to be accepted.
            if (at_last) begin
              state <= S_DRAIN;
            end else begin
              cnt  <= cnt + 1'b1;
              base <= base + ADDR_W'(NUM_READ);
            end
          end
        end
        S_DRAIN: begin
          if (vld_p0 && bus.i_ready) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
            done_r  <= 1'b1;
            state   <= S_IDLE;
            base    <= '0;
            cnt     <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_data  = data_p0;
  assign bus.o_valid = vld_p0;
  assign bus.o_beat  = beat_p0;
  assign bus.o_last  = last_p0;
  assign o_busy      = (state != S_IDLE);
  assign o_done      = done_r;

endmodule

// File: tb/tb_sram_frame_reader.sv
// Bench for sram_frame_reader: SRAM model returns mem[a] = a, and every
// frame request pushes its 800 expected beats to a queue that is drained
// as beats are accepted.
module tb_sram_frame_reader;

  localparam int NR     = 6;
  localparam int ND     = 4800;
  localparam int NBEATS = ND / NR;
  localparam int LIMIT  = 3000;

  typedef struct {
    logic [NR-1:0][15:0] data;
    logic [9:0]          beat;
    logic                last;
  } exp_t;

  logic clk;
  logic rst;
  logic start;
  logic busy;
  logic done;

  int   n_cmp;
  int   n_bad;
  int   addr_max;
  exp_t exp_q[$];

  sram_frame_reader_if #(.NUM_READ(NR)) bus ();

  sram_frame_reader #(
    .NUM_READ(NR),
    .NUM_DATA(ND)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_start(start),
    .o_busy (busy),
    .o_done (done),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational SRAM: each word holds its own address.
  always_comb begin
    for (int k = 0; k < NR; k++) begin
      bus.i_read_data[k] = 16'(bus.o_read_address[k]);
    end
  end

  task automatic push_frame();
    exp_t e;
    for (int b = 0; b < NBEATS; b++) begin
      e.beat = 10'(b);
      e.last = (b == NBEATS - 1);
      for (int k = 0; k < NR; k++) e.data[k] = 16'(b * NR + k);
      exp_q.push_back(e);
    end
  endtask

  // Runs one frame and scores every accepted beat against the queue.
  // mode 0: ready=1, 1: random ready, 2: start pulses at beats 10/500,
  // 3: stall 5 cycles on the last beat, 4: reset at beat 300,
  // 5: raise start in the o_done cycle and leave it for the next frame.
  // done_it = clock edges from the start-sampling edge to o_done (-1 if none).
  task automatic run_frame(input int mode, input bit issue_start, output int done_it);
    exp_t                e;
    exp_t                held;
    bit                  hold;
    bit                  p10;
    bit                  p500;
    int                  stall;
    logic [NR-1:0][12:0] addr_k;
    done_it = -1;
    hold    = 1'b0;
    p10     = 1'b0;
    p500    = 1'b0;
    stall   = 0;
    for (int k = 0; k < NR; k++) addr_k[k] = 13'(k);
    if (issue_start) begin
      @(posedge clk); #1;
      start = 1'b1;
    end
    push_frame();
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_read_address !== addr_k) begin
      n_bad++;
      $display("FAIL scan_entry mode%0d: busy=%b valid=%b addr=%h, want busy=1 valid=0 addr=%h",
               mode, busy, bus.o_valid, bus.o_read_address, addr_k);
    end
    for (int it = 1; it <= LIMIT; it++) begin
      @(posedge clk); #1;
      start = 1'b0;
      case (mode)
        1: bus.i_ready = ($urandom_range(0, 1) == 1);
        2: begin
          if (bus.o_valid && bus.o_beat == 10'd10 && !p10) begin
            start = 1'b1; p10 = 1'b1;
          end else if (bus.o_valid && bus.o_beat == 10'd500 && !p500) begin
            start = 1'b1; p500 = 1'b1;
          end
        end
        3: begin
          if (bus.o_valid && bus.o_last && stall < 5) begin
            bus.i_ready = 1'b0; stall++;
          end else begin
            bus.i_ready = 1'b1;
          end
        end
        4: begin
          if (bus.o_valid && bus.o_beat == 10'd300) begin
            rst = 1'b1;
            #1;
            n_cmp++;
            if (bus.o_valid !== 1'b0 || bus.o_data !== '0 || bus.o_beat !== '0 || bus.o_last !== 1'b0 ||
                done !== 1'b0 || busy !== 1'b0 || bus.o_read_address !== addr_k) begin
              n_bad++;
              $display("FAIL async_reset: valid=%b data=%h beat=%0d last=%b done=%b busy=%b addr=%h, want all 0, addr=%h",
                       bus.o_valid, bus.o_data, bus.o_beat, bus.o_last, done, busy, bus.o_read_address, addr_k);
            end
            @(posedge clk); #1;
            rst = 1'b0;
            exp_q.delete();
            return;
          end
        end
        default: ;
      endcase
      @(negedge clk);
      for (int k = 0; k < NR; k++) begin
        if (int'(bus.o_read_address[k]) > addr_max) addr_max = int'(bus.o_read_address[k]);
      end
      if (hold) begin
        n_cmp++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== held.data || bus.o_beat !== held.beat ||
            bus.o_last !== held.last) begin
          n_bad++;
          $display("FAIL stall_hold: valid=%b beat=%0d last=%b data=%h, want valid=1 beat=%0d last=%b data=%h",
                   bus.o_valid, bus.o_beat, bus.o_last, bus.o_data, held.beat, held.last, held.data);
        end
      end
      if (mode == 3 && !bus.i_ready) begin
        n_cmp++;
        if (bus.o_valid !== 1'b1 || bus.o_last !== 1'b1 || done !== 1'b0) begin
          n_bad++;
          $display("FAIL last_stall: valid=%b last=%b done=%b, want valid=1 last=1 done=0",
                   bus.o_valid, bus.o_last, done);
        end
      end
      if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL extra_beat: got beat=%0d, want no beat", bus.o_beat);
        end else begin
          e = exp_q.pop_front();
          if (bus.o_data !== e.data || bus.o_beat !== e.beat || bus.o_last !== e.last) begin
            n_bad++;
            $display("FAIL beat%0d: got beat=%0d last=%b data=%h, want beat=%0d last=%b data=%h",
                     e.beat, bus.o_beat, bus.o_last, bus.o_data, e.beat, e.last, e.data);
          end
        end
      end
      hold = (bus.o_valid === 1'b1 && bus.i_ready !== 1'b1);
      held.data = bus.o_data;
      held.beat = bus.o_beat;
      held.last = bus.o_last;
      if (done === 1'b1) begin
        done_it = it;
        if (mode == 5) start = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (done_it < 0) begin
      n_bad++;
      $display("FAIL timeout mode%0d: no o_done within %0d cycles, want o_done", mode, LIMIT);
    end
  endtask

  task automatic test_reset();
    logic [NR-1:0][12:0] addr_k;
    for (int k = 0; k < NR; k++) addr_k[k] = 13'(k);
    #12;
    n_cmp++;
    if (bus.o_valid !== 1'b0 || bus.o_data !== '0 || bus.o_beat !== '0 || bus.o_last !== 1'b0 ||
        done !== 1'b0 || busy !== 1'b0 || bus.o_read_address !== addr_k) begin
      n_bad++;
      $display("FAIL reset_state: valid=%b data=%h beat=%0d last=%b done=%b busy=%b addr=%h, want 0s addr=%h",
               bus.o_valid, bus.o_data, bus.o_beat, bus.o_last, done, busy, bus.o_read_address, addr_k);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || bus.o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_hold: busy=%b valid=%b, want 0 0", busy, bus.o_valid);
    end
  endtask

  task automatic test_full_frame();
    int d;
    bus.i_ready = 1'b1;
    addr_max = 0;
    run_frame(0, 1'b1, d);
    n_cmp++;
    if (d !== NBEATS + 1) begin
      n_bad++;
      $display("FAIL frame_latency: o_done after %0d edges, want %0d", d, NBEATS + 1);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL frame_count: %0d beats missing, want 0", exp_q.size());
    end
    n_cmp++;
    if (addr_max != ND - 1) begin
      n_bad++;
      $display("FAIL addr_max: got %0d, want %0d", addr_max, ND - 1);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_last !== 1'b0) begin
      n_bad++;
      $display("FAIL done_pulse: done=%b busy=%b valid=%b last=%b, want 0 0 0 0",
               done, busy, bus.o_valid, bus.o_last);
    end
  endtask

  task automatic test_random_ready();
    int d;
    run_frame(1, 1'b1, d);
    n_cmp++;
    if (d < NBEATS + 1 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL random_frame: done at %0d with %0d beats left, want >= %0d and 0", d, exp_q.size(), NBEATS + 1);
    end
    bus.i_ready = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_start_ignored();
    int d;
    int busy_cnt;
    bus.i_ready = 1'b1;
    run_frame(2, 1'b1, d);
    n_cmp++;
    if (d !== NBEATS + 1 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL start_ignored: done at %0d with %0d left, want %0d and 0", d, exp_q.size(), NBEATS + 1);
    end
    busy_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy === 1'b1 || bus.o_valid === 1'b1) busy_cnt++;
    end
    n_cmp++;
    if (busy_cnt != 0) begin
      n_bad++;
      $display("FAIL no_second_frame: busy/valid seen %0d cycles, want 0", busy_cnt);
    end
    exp_q.delete();
  endtask

  task automatic test_last_stall();
    int d;
    bus.i_ready = 1'b1;
    run_frame(3, 1'b1, d);
    n_cmp++;
    if (d !== NBEATS + 6 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL stall_done: done at %0d with %0d left, want %0d and 0", d, exp_q.size(), NBEATS + 6);
    end
    bus.i_ready = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    int d;
    int bad_cnt;
    bus.i_ready = 1'b1;
    run_frame(4, 1'b1, d);
    bad_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1 || bus.o_valid === 1'b1) bad_cnt++;
    end
    n_cmp++;
    if (bad_cnt != 0) begin
      n_bad++;
      $display("FAIL abort_quiet: done/busy/valid seen %0d cycles after reset, want 0", bad_cnt);
    end
    run_frame(0, 1'b1, d);
    n_cmp++;
    if (d !== NBEATS + 1 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL restart_frame: done at %0d with %0d left, want %0d and 0", d, exp_q.size(), NBEATS + 1);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int d;
    bus.i_ready = 1'b1;
    run_frame(5, 1'b1, d);
    n_cmp++;
    if (d !== NBEATS + 1) begin
      n_bad++;
      $display("FAIL b2b_first: done at %0d, want %0d", d, NBEATS + 1);
    end
    run_frame(0, 1'b0, d);
    n_cmp++;
    if (d !== NBEATS + 1 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_second: done at %0d with %0d left, want %0d and 0", d, exp_q.size(), NBEATS + 1);
    end
    exp_q.delete();
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    addr_max    = 0;
    rst         = 1'b1;
    start       = 1'b0;
    bus.i_ready = 1'b0;
    test_reset();
    test_full_frame();
    test_random_ready();
    test_start_ignored();
    test_last_stall();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_frame_reader.md
SRAM_FRAME_READER -- requirements
Module: sram_frame_reader

Interface
REQ-001 SHALL have parameter NUM_READ, default 6, number of parallel SRAM read lanes (equal to SRAM_PARALLEL).
REQ-002 SHALL have parameter NUM_DATA, default 4800 (80*60), pixels per frame.
REQ-003 SHALL have one clock and asynchronous active-high reset: i_clk  in  1  rising-edge clock.
REQ-004 i_rst  in  1  asynchronous, active-high reset.
REQ-005 i_start  in  1  single-cycle request to scan one frame.
REQ-006 o_read_address  out  13 x NUM_READ  SRAM read addresses, lane k = base+k.
REQ-007 i_read_data  in  16 x NUM_READ  SRAM read data, combinational (same-cycle) response to o_read_address.
REQ-008 o_data  out  16 x NUM_READ  registered pixel beat, lane k = pixel base+k.
REQ-009 o_valid  out  1  o_data/o_beat/o_last valid.
REQ-010 i_ready  in  1  downstream accepts beat when o_valid & i_ready.
REQ-011 o_beat  out  10  beat index of o_data (0..799).
REQ-012 o_last  out  1  o_data is final beat of frame.
REQ-013 o_busy  out  1  high in SCAN or DRAIN.
REQ-014 o_done  out  1  one-cycle pulse after final beat handshake.

Function
REQ-015 SHALL implement FSM states IDLE, SCAN, DRAIN.
REQ-016 IDLE: i_start=1 -> SCAN, base<=0, beat counter<=0; i_start=0 -> stay.
REQ-017 i_start SHALL be ignored while o_busy=1.
REQ-018 In SCAN, o_read_address[k] SHALL equal base+k; base advances by NUM_READ per load (adder, no multiplier).
REQ-019 Outside SCAN, o_read_address[k] SHALL equal k (base held at 0).
REQ-020 load = SCAN & (!o_valid | i_ready); on load: o_data<=i_read_data, o_valid<=1, o_beat<=counter, o_last<=(counter==NUM_DATA/NUM_READ-1).
REQ-021 On load with counter<799: counter++, base+=6; with counter==799: -> DRAIN, base and counter held.
REQ-022 SCAN without load (o_valid=1, i_ready=0): addresses, o_data, o_beat, o_last SHALL hold stable.
REQ-023 In SCAN, o_valid & i_ready & !load is impossible; handshake and load coincide, giving one beat per cycle at i_ready=1.
REQ-024 DRAIN: o_valid & i_ready -> o_valid<=0, o_last<=0, o_done<=1 for one cycle, -> IDLE.
REQ-025 Latency: i_start sampled at edge N; SCAN from N+1 with addresses 0..5; first o_valid at edge N+2.
REQ-026 Full frame at i_ready=1: exactly 800 beats on consecutive cycles, o_done one cycle after beat 799 handshake; i_start-to-o_done = 802 cycles.
REQ-027 Maximum address SHALL be 4799; no address >= NUM_DATA ever driven.
REQ-028 i_start asserted in the o_done cycle SHALL start a new frame (FSM already IDLE).
REQ-029 NUM_DATA SHALL be divisible by NUM_READ; no partial beats.

Reset
REQ-030 On i_rst=1, immediately: state IDLE, base 0, counter 0, o_data 0, o_valid 0, o_beat 0, o_last 0, o_done 0, o_busy 0.
REQ-031 Reset mid-SCAN/DRAIN SHALL abort the frame with no o_done; next scan starts only on fresh i_start.

Structure
REQ-032 Shared package frame_pkg SHALL hold PIXEL_COLUMN=80, PIXEL_ROW=60, NUM_DATA, SRAM_PARALLEL=6, ADDR_W=13, DATA_W=16, BEATS=NUM_DATA/SRAM_PARALLEL, and the FSM state enum.
REQ-033 Single module; no sub-module; counter, address generator, output register inline.

Verification
REQ-034 Reset then i_start, i_ready=1, SRAM model mem[a]=a -> 800 consecutive beats, beat b lanes = 6b..6b+5, o_last on beat 799 only, o_done 1 cycle later.
REQ-035 i_ready toggled pseudo-randomly (50%) -> same 800-beat sequence, no loss/duplication, o_data stable while o_valid & !i_ready.
REQ-036 i_start pulsed at beats 10 and 500 -> ignored, single frame of 800 beats.
REQ-037 i_ready=0 at beat 799 for 5 cycles -> o_valid, o_last held 5 cycles, o_done only after handshake.
REQ-038 i_rst asserted at beat 300 -> all outputs 0 asynchronously, no o_done; new i_start -> beat 0 at addresses 0..5.
REQ-039 i_start in o_done cycle -> second frame starts, beat 0 two cycles later.
